// File: rtl/lcd_sprite_overlay_if.sv
// Pixel-stream / ROM / result bundle for the LCD sprite overlay.
// The pixel stream has no backpressure: a pixel is taken on every rising
// clock edge where pix_valid is high, and out_valid marks each composited
// pixel exactly once. The ROM port is a plain synchronous read with
// one-cycle latency, so it carries no handshake either.
interface lcd_sprite_overlay_if #(
    parameter int X_WIDTH     = 11,
    parameter int Y_WIDTH     = 10,
    parameter int COLOR_WIDTH = 16,
    parameter int ADDR_WIDTH  = 8
);
    logic                   frame_start;
    logic                   pix_valid;
    logic [X_WIDTH-1:0]     pix_x;
    logic [Y_WIDTH-1:0]     pix_y;
    logic [COLOR_WIDTH-1:0] bg_color;
    logic                   sprite_en;
    logic [X_WIDTH-1:0]     sprite_pos_x;
    logic [Y_WIDTH-1:0]     sprite_pos_y;
    logic [COLOR_WIDTH-1:0] sprite_color;
    logic [ADDR_WIDTH-1:0]  rom_addr;
    logic                   rom_data;
    logic                   out_valid;
    logic [COLOR_WIDTH-1:0] out_color;
    logic [15:0]            hit_count;

    // Scan logic, sprite registers and bitmap ROM side.
    modport master (
        output frame_start, pix_valid, pix_x, pix_y, bg_color,
        output sprite_en, sprite_pos_x, sprite_pos_y, sprite_color,
        output rom_data,
        input  rom_addr, out_valid, out_color, hit_count
    );

    // Overlay block side.
    modport slave (
        input  frame_start, pix_valid, pix_x, pix_y, bg_color,
        input  sprite_en, sprite_pos_x, sprite_pos_y, sprite_color,
        input  rom_data,
        output rom_addr, out_valid, out_color, hit_count
    );
endinterface

// File: rtl/lcd_sprite_overlay.sv
// Sprite overlay for the LCD pixel stream. A pixel inside the (shadowed)
// sprite window addresses the 1-bit bitmap ROM; two cycles later the ROM bit
// selects sprite colour or the pixel's own background colour. Sprite
// registers are captured on frame_start so a frame never mixes two sprite
// positions, and the number of sprite-coloured pixels per frame is reported.
module lcd_sprite_overlay #(
    parameter int SPR_W       = 16,
    parameter int SPR_H       = 16,
    parameter int ADDR_WIDTH  = 8,
    parameter int X_WIDTH     = 11,
    parameter int Y_WIDTH     = 10,
    parameter int COLOR_WIDTH = 16,
    parameter int SCALE_SHIFT = 0
) (
    input  logic                clk,
    input  logic                rst,
    lcd_sprite_overlay_if.slave bus
);
    // Window size on screen after upscaling, in the widened difference width.
    localparam logic [X_WIDTH:0] LP_WIN_W = (X_WIDTH+1)'(SPR_W << SCALE_SHIFT);
    localparam logic [Y_WIDTH:0] LP_WIN_H = (Y_WIDTH+1)'(SPR_H << SCALE_SHIFT);

    // Frame shadows
    logic                   r_en;
    logic [X_WIDTH-1:0]     r_pos_x;
    logic [Y_WIDTH-1:0]     r_pos_y;
    logic [COLOR_WIDTH-1:0] r_color;

    // Pipeline
    logic [ADDR_WIDTH-1:0]  r_rom_addr;
    logic                   r_valid_s1, r_hit_s1;
    logic [COLOR_WIDTH-1:0] r_bg_s1, r_color_s1;
    logic                   r_valid_s2, r_hit_s2;
    logic [COLOR_WIDTH-1:0] r_bg_s2, r_color_s2;
    logic                   r_out_valid;
    logic [COLOR_WIDTH-1:0] r_out_color;

    // Hit statistics
    logic [15:0]            r_counter;
    logic [15:0]            r_hit_count;

    logic [X_WIDTH:0]       w_dx, w_bx;
    logic [Y_WIDTH:0]       w_dy, w_by;
    logic                   w_hit;
    logic [ADDR_WIDTH-1:0]  w_addr;
    logic                   w_retire_hit;
    logic [15:0]            w_cnt_inc;

    // Differences are one bit wider so a pixel left of / above the sprite
    // shows up as a set top bit instead of wrapping into the window.
    assign w_dx = {1'b0, bus.pix_x} - {1'b0, r_pos_x};
    assign w_dy = {1'b0, bus.pix_y} - {1'b0, r_pos_y};

    assign w_hit = r_en
                 & ~w_dx[X_WIDTH] & (w_dx < LP_WIN_W)
                 & ~w_dy[Y_WIDTH] & (w_dy < LP_WIN_H);

    // Bitmap coordinates after undoing the upscale; row-major address.
    assign w_bx   = w_dx >> SCALE_SHIFT;
    assign w_by   = w_dy >> SCALE_SHIFT;
    assign w_addr = ADDR_WIDTH'(w_by) * ADDR_WIDTH'(SPR_W) + ADDR_WIDTH'(w_bx);

    // A sprite-coloured pixel leaves the pipeline this cycle.
    assign w_retire_hit = r_valid_s2 & r_hit_s2 & bus.rom_data;
    assign w_cnt_inc    = (r_counter == 16'hFFFF) ? r_counter : r_counter + 16'd1;

    // Capture sprite registers at frame start; the pixel sampled on the same
    // edge still sees the previous values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_en    <= 1'b0;
            r_pos_x <= '0;
            r_pos_y <= '0;
            r_color <= '0;
        end else if (bus.frame_start) begin
            r_en    <= bus.sprite_en;
            r_pos_x <= bus.sprite_pos_x;
            r_pos_y <= bus.sprite_pos_y;
            r_color <= bus.sprite_color;
        end
    end

    // Stage 1: window test, ROM address, and carry the pixel's colours.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rom_addr <= '0;
            r_valid_s1 <= 1'b0;
            r_hit_s1   <= 1'b0;
            r_bg_s1    <= '0;
            r_color_s1 <= '0;
        end else begin
            r_valid_s1 <= bus.pix_valid;
            r_hit_s1   <= bus.pix_valid & w_hit;
            r_bg_s1    <= bus.bg_color;
            r_color_s1 <= r_color;
            if (bus.pix_valid && w_hit) begin
                r_rom_addr <= w_addr;
            end
        end
    end

    // Stage 2: wait alongside the ROM's registered read.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid_s2 <= 1'b0;
            r_hit_s2   <= 1'b0;
            r_bg_s2    <= '0;
            r_color_s2 <= '0;
        end else begin
            r_valid_s2 <= r_valid_s1;
            r_hit_s2   <= r_hit_s1;
            r_bg_s2    <= r_bg_s1;
            r_color_s2 <= r_color_s1;
        end
    end

    // Output: composite with the returned bitmap bit; colour holds on bubbles.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_color <= '0;
        end else begin
            r_out_valid <= r_valid_s2;
            if (r_valid_s2) begin
                r_out_color <= (r_hit_s2 && bus.rom_data) ? r_color_s2 : r_bg_s2;
            end
        end
    end

    // Per-frame hit counter: a hit retiring on the frame_start edge is
    // included in the published count and also starts the new count.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_counter   <= '0;
            r_hit_count <= '0;
        end else if (bus.frame_start) begin
            r_hit_count <= w_retire_hit ? w_cnt_inc : r_counter;
            r_counter   <= {15'd0, w_retire_hit};
        end else if (w_retire_hit) begin
            r_counter   <= w_cnt_inc;
        end
    end

    assign bus.rom_addr  = r_rom_addr;
    assign bus.out_valid = r_out_valid;
    assign bus.out_color = r_out_color;
    assign bus.hit_count = r_hit_count;
endmodule

// File: tb/tb_lcd_sprite_overlay.sv
// Bench for lcd_sprite_overlay: two instances (scale 1x and 2x) share one
// stimulus stream, each with its own bitmap ROM port, checked against a
// pixel-level model plus directed literal expectations.
`timescale 1ns/1ps
module tb_lcd_sprite_overlay;
    localparam int XW = 11;
    localparam int YW = 10;
    localparam int CW = 16;
    localparam int AW = 8;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    lcd_sprite_overlay_if #(.X_WIDTH(XW), .Y_WIDTH(YW), .COLOR_WIDTH(CW), .ADDR_WIDTH(AW)) bus0 ();
    lcd_sprite_overlay_if #(.X_WIDTH(XW), .Y_WIDTH(YW), .COLOR_WIDTH(CW), .ADDR_WIDTH(AW)) bus1 ();

    lcd_sprite_overlay #(.SPR_W(16), .SPR_H(16), .ADDR_WIDTH(AW), .X_WIDTH(XW), .Y_WIDTH(YW),
                         .COLOR_WIDTH(CW), .SCALE_SHIFT(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
    lcd_sprite_overlay #(.SPR_W(16), .SPR_H(16), .ADDR_WIDTH(AW), .X_WIDTH(XW), .Y_WIDTH(YW),
                         .COLOR_WIDTH(CW), .SCALE_SHIFT(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    // Bitmap ROM: synchronous read, one cycle latency.
    logic bitmap [256];
    always @(posedge clk) begin
        bus0.rom_data <= bitmap[bus0.rom_addr];
        bus1.rom_data <= bitmap[bus1.rom_addr];
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s[inst%0d] @%0t: got %0h expected %0h", name, k, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Each pixel's fate is decided from the screen geometry when it is
    // sampled; it then appears on the output two clocks later.
    typedef struct { logic v; logic sprite; logic [15:0] col; } pix_t;
    pix_t        flight [2][$];
    logic        model_ready = 1'b0;
    int          sh_en, sh_x, sh_y;
    logic [15:0] sh_col;
    logic        e_valid [2];
    logic [15:0] e_color [2];
    logic [7:0]  e_addr  [2];
    int          e_hc    [2];
    int          cnt     [2];

    always @(posedge clk) begin : model
        if (rst) begin
            model_ready = 1'b1;
            sh_en = 0; sh_x = 0; sh_y = 0; sh_col = '0;
            for (int k = 0; k < 2; k++) begin
                flight[k].delete();
                e_valid[k] = 1'b0; e_color[k] = '0; e_addr[k] = '0;
                e_hc[k] = 0; cnt[k] = 0;
            end
        end else if (model_ready) begin
            for (int k = 0; k < 2; k++) begin
                pix_t p, r;
                int   px, py, dx, dy, rh;
                r = '{v: 1'b0, sprite: 1'b0, col: 16'h0};
                if (flight[k].size() == 2) r = flight[k].pop_front();
                e_valid[k] = r.v;
                if (r.v) e_color[k] = r.col;
                rh = (r.v && r.sprite) ? 1 : 0;
                if (bus0.frame_start) begin
                    e_hc[k] = (cnt[k] + rh > 65535) ? 65535 : cnt[k] + rh;
                    cnt[k]  = rh;
                end else if (rh == 1 && cnt[k] < 65535) begin
                    cnt[k]++;
                end
                px = bus0.pix_x; py = bus0.pix_y;
                dx = px - sh_x;  dy = py - sh_y;
                p.v = bus0.pix_valid;
                p.sprite = 1'b0;
                p.col = bus0.bg_color;
                if (bus0.pix_valid && sh_en != 0 && dx >= 0 && dy >= 0 &&
                    dx < (16 << k) && dy < (16 << k)) begin
                    int a;
                    a = (dy >> k) * 16 + (dx >> k);
                    e_addr[k] = 8'(a);
                    p.sprite = bitmap[a];
                    if (p.sprite) p.col = sh_col;
                end
                flight[k].push_back(p);
            end
            if (bus0.frame_start) begin
                sh_en = bus0.sprite_en ? 1 : 0;
                sh_x = bus0.sprite_pos_x; sh_y = bus0.sprite_pos_y;
                sh_col = bus0.sprite_color;
            end
        end
    end

    // ---------------- scoreboard compare, every cycle ----------------
    always @(negedge clk) begin
        if (model_ready) begin
            chk("out_valid", 0, 32'(bus0.out_valid), 32'(e_valid[0]));
            chk("out_valid", 1, 32'(bus1.out_valid), 32'(e_valid[1]));
            chk("out_color", 0, 32'(bus0.out_color), 32'(e_color[0]));
            chk("out_color", 1, 32'(bus1.out_color), 32'(e_color[1]));
            chk("rom_addr",  0, 32'(bus0.rom_addr),  32'(e_addr[0]));
            chk("rom_addr",  1, 32'(bus1.rom_addr),  32'(e_addr[1]));
            chk("hit_count", 0, 32'(bus0.hit_count), 32'(e_hc[0]));
            chk("hit_count", 1, 32'(bus1.hit_count), 32'(e_hc[1]));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
        bus0.pix_valid = 1'b0;  bus1.pix_valid = 1'b0;
        bus0.frame_start = 1'b0; bus1.frame_start = 1'b0;
    endtask

    task automatic set_sprite(input logic en, input int x, input int y, input logic [15:0] c);
        bus0.sprite_en = en;              bus1.sprite_en = en;
        bus0.sprite_pos_x = XW'(x);       bus1.sprite_pos_x = XW'(x);
        bus0.sprite_pos_y = YW'(y);       bus1.sprite_pos_y = YW'(y);
        bus0.sprite_color = c;            bus1.sprite_color = c;
    endtask

    task automatic load_pix(input int x, input int y, input logic [15:0] bg);
        bus0.pix_valid = 1'b1;      bus1.pix_valid = 1'b1;
        bus0.pix_x = XW'(x);        bus1.pix_x = XW'(x);
        bus0.pix_y = YW'(y);        bus1.pix_y = YW'(y);
        bus0.bg_color = bg;         bus1.bg_color = bg;
    endtask

    task automatic pix(input int x, input int y, input logic [15:0] bg);
        load_pix(x, y, bg);
        step();
    endtask

    task automatic fs();
        bus0.frame_start = 1'b1; bus1.frame_start = 1'b1;
        step();
    endtask

    // ---------------- directed + random stimulus ----------------
    initial begin
        bus0.frame_start = 1'b0; bus1.frame_start = 1'b0;
        bus0.pix_valid = 1'b0;   bus1.pix_valid = 1'b0;
        load_pix(0, 0, 16'h0);
        bus0.pix_valid = 1'b0;   bus1.pix_valid = 1'b0;
        set_sprite(1'b0, 0, 0, 16'h0);
        for (int i = 0; i < 256; i++) bitmap[i] = 1'b0;
        bitmap[0] = 1'b1;

        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        chk("rst_hit_count", 0, 32'(bus0.hit_count), 32'h0);
        chk("rst_out_valid", 0, 32'(bus0.out_valid), 32'h0);

        // Window origin, bit 0 set -> sprite colour.
        set_sprite(1'b1, 100, 50, 16'hF800);
        fs();
        pix(100, 50, 16'h0000);
        chk("origin_addr", 0, 32'(bus0.rom_addr), 32'd0);
        step(); step();
        chk("origin_valid", 0, 32'(bus0.out_valid), 32'd1);
        chk("origin_color", 0, 32'(bus0.out_color), 32'hF800);

        // Bottom-right corner, bit 255 clear -> background.
        pix(115, 65, 16'h001F);
        chk("corner_addr", 0, 32'(bus0.rom_addr), 32'd255);
        step(); step();
        chk("corner_color", 0, 32'(bus0.out_color), 32'h001F);

        // Just right of and just left of the window.
        pix(116, 50, 16'h07E0);
        chk("right_addr_hold", 0, 32'(bus0.rom_addr), 32'd255);
        step(); step();
        chk("right_color", 0, 32'(bus0.out_color), 32'h07E0);
        pix(99, 50, 16'h1234);
        chk("left_addr_hold", 0, 32'(bus0.rom_addr), 32'd255);
        step(); step();
        chk("left_color", 0, 32'(bus0.out_color), 32'h1234);

        // 2x upscale addressing.
        set_sprite(1'b1, 0, 0, 16'hF800);
        fs();
        pix(3, 5, 16'h0);
        chk("scale_addr", 1, 32'(bus1.rom_addr), 32'd33);
        pix(32, 0, 16'h0);
        chk("scale_outside", 1, 32'(bus1.rom_addr), 32'd33);
        step(); step();

        // Clipping at the right edge of the coordinate range.
        set_sprite(1'b1, 2040, 10, 16'h07E0);
        fs();
        for (int x = 2040; x < 2048; x++) pix(x, 10, 16'h0);
        chk("clip_last_addr", 0, 32'(bus0.rom_addr), 32'd7);
        chk("clip_last_addr", 1, 32'(bus1.rom_addr), 32'd3);
        pix(0, 11, 16'h0);
        chk("clip_nowrap", 0, 32'(bus0.rom_addr), 32'd7);
        step(); step();

        // Full window of an all-ones bitmap with random gaps.
        for (int i = 0; i < 256; i++) bitmap[i] = 1'b1;
        set_sprite(1'b1, 200, 100, 16'h001F);
        fs();
        for (int y = 0; y < 16; y++) begin
            if (y == 8) set_sprite(1'b1, 0, 0, 16'hF800);
            for (int x = 0; x < 16; x++) begin
                repeat ($urandom_range(0, 2)) step();
                pix(200 + x, 100 + y, 16'($urandom));
            end
        end
        chk("midframe_color", 0, 32'(bus0.out_color), 32'h001F);
        step(); step();
        fs();
        chk("frame_hits", 0, 32'(bus0.hit_count), 32'd256);
        chk("frame_hits", 1, 32'(bus1.hit_count), 32'd256);

        // Reset with two pixels in flight.
        set_sprite(1'b1, 200, 100, 16'hF800);
        fs();
        pix(200, 100, 16'h0);
        pix(201, 100, 16'h0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("rst_flight_valid", 0, 32'(bus0.out_valid), 32'd0);
            step();
        end
        chk("rst_flight_hits", 0, 32'(bus0.hit_count), 32'd0);

        // Pixel on the frame_start edge uses the old (disabled) sprite.
        set_sprite(1'b1, 300, 300, 16'hF800);
        bus0.frame_start = 1'b1; bus1.frame_start = 1'b1;
        pix(300, 300, 16'h1234);
        step(); step();
        chk("coincident_old", 0, 32'(bus0.out_color), 32'h1234);
        pix(300, 300, 16'h1234);
        step(); step();
        chk("after_load_new", 0, 32'(bus0.out_color), 32'hF800);

        // Randomised traffic against the model.
        for (int i = 0; i < 256; i++) bitmap[i] = 1'($urandom);
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 99) < 3) begin
                set_sprite(1'($urandom_range(0, 7) != 0),
                           ($urandom_range(0, 3) == 0) ? $urandom_range(2020, 2047) : $urandom_range(0, 48),
                           ($urandom_range(0, 5) == 0) ? $urandom_range(1000, 1023) : $urandom_range(0, 48),
                           16'($urandom));
            end
            if ($urandom_range(0, 149) == 0) begin
                bus0.frame_start = 1'b1; bus1.frame_start = 1'b1;
            end
            if ($urandom_range(0, 3) != 0) begin
                load_pix(($urandom_range(0, 3) == 0) ? $urandom_range(2016, 2047) : $urandom_range(0, 63),
                         ($urandom_range(0, 5) == 0) ? $urandom_range(990, 1023) : $urandom_range(0, 63),
                         16'($urandom));
            end
            step();
        end
        step(); step();
        fs();
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
